// File: rtl/bin_bbox_detect.sv
`default_nettype none
// ============================================================================
// Module      : bin_bbox_detect
// Description : Per-frame bounding-box locator for a binarized pixel stream.
//               Tracks pixel coordinates, accumulates min/max column and row
//               of foreground pixels plus their count, and publishes the box
//               at each vsync rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_bbox_detect #(
  parameter int   H_ACTIVE   = 640,
  parameter int   V_ACTIVE   = 480,
  parameter int   XW         = 10,
  parameter int   YW         = 9,
  parameter int   CW         = 19,
  parameter logic FG_LEVEL   = 1'b0,
  parameter int   MIN_PIXELS = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bin,
  input  logic          in_href,
  input  logic          in_vsync,
  input  logic          in_clken,
  output logic [XW-1:0] box_left,
  output logic [XW-1:0] box_right,
  output logic [YW-1:0] box_top,
  output logic [YW-1:0] box_bottom,
  output logic [CW-1:0] pix_count,
  output logic          box_found,
  output logic          box_valid
);

  // Counters carry one extra bit so they can hold the saturation value even
  // when H_ACTIVE / V_ACTIVE equal a power of two.
  localparam logic [XW:0]   X_END   = (XW+1)'(H_ACTIVE);
  localparam logic [YW:0]   Y_END   = (YW+1)'(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);
  localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};

  typedef enum logic {
    SYNC  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [XW:0]   x;
  logic [YW:0]   y;
  logic          href_d;
  logic          vsync_d;
  logic [XW-1:0] min_x, max_x;
  logic [YW-1:0] min_y, max_y;
  logic [CW-1:0] cnt;

  logic          pix_ev;
  logic          vs_rise;
  logic          href_fall;
  logic          fg_pix;
  logic [XW-1:0] x_c;
  logic [YW-1:0] y_c;
  logic          acc_clr;
  logic          acc_en;
  logic          res_load;

  assign pix_ev    = in_href & in_clken & ~in_vsync;
  assign vs_rise   = in_vsync & ~vsync_d;
  assign href_fall = href_d & ~in_href;
  assign x_c       = x[XW-1:0];
  assign y_c       = y[YW-1:0];
  // Pixels outside the active window never reach the accumulators.
  assign fg_pix    = pix_ev & (bin == FG_LEVEL) & (x < X_END) & (y < Y_END);

  // Edge-detect registers for href and vsync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      href_d  <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      href_d  <= in_href;
      vsync_d <= in_vsync;
    end
  end

  // Column counter: cleared outside href, advances after each pixel event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
    end else if (!in_href) begin
      x <= '0;
    end else if (pix_ev && (x < X_END)) begin
      x <= x + (XW+1)'(1);
    end
  end

  // Row counter: cleared at frame end, advances on each line end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y <= '0;
    end else if (vs_rise) begin
      y <= '0;
    end else if (href_fall && (y < Y_END)) begin
      y <= y + (YW+1)'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SYNC;
    else       state <= state_next;
  end

  // FSM next state and control strobes; the first vsync edge only aligns.
  always_comb begin
    state_next = state;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    res_load   = 1'b0;
    case (state)
      SYNC: begin
        if (vs_rise) begin
          acc_clr    = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        acc_en = fg_pix;
        if (vs_rise) begin
          res_load = 1'b1;
          acc_clr  = 1'b1;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  // Foreground accumulators: min/max coordinates and saturating count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_x <= X_LAST;
      max_x <= '0;
      min_y <= Y_LAST;
      max_y <= '0;
      cnt   <= '0;
    end else if (acc_clr) begin
      min_x <= X_LAST;
      max_x <= '0;
      min_y <= Y_LAST;
      max_y <= '0;
      cnt   <= '0;
    end else if (acc_en) begin
      if (x_c < min_x) min_x <= x_c;
      if (x_c > max_x) max_x <= x_c;
      if (y_c < min_y) min_y <= y_c;
      if (y_c > max_y) max_y <= y_c;
      if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
    end
  end

  // Result latch: published once per frame end, zeroed box when too sparse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      box_left   <= '0;
      box_right  <= '0;
      box_top    <= '0;
      box_bottom <= '0;
      pix_count  <= '0;
      box_found  <= 1'b0;
      box_valid  <= 1'b0;
    end else begin
      box_valid <= res_load;
      if (res_load) begin
        pix_count <= cnt;
        if (cnt >= MIN_CNT) begin
          box_found  <= 1'b1;
          box_left   <= min_x;
          box_right  <= max_x;
          box_top    <= min_y;
          box_bottom <= max_y;
        end else begin
          box_found  <= 1'b0;
          box_left   <= '0;
          box_right  <= '0;
          box_top    <= '0;
          box_bottom <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin_bbox_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_bbox_detect
// Description : Scoreboard bench for bin_bbox_detect. Two instances share the
//               stimulus: one with MIN_PIXELS=16, one with MIN_PIXELS=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_bbox_detect;

  logic clk = 1'b0;
  logic reset, bin, in_href, in_vsync, in_clken;

  logic [9:0]  l16, r16, l1, r1;
  logic [8:0]  t16, b16, t1, b1;
  logic [18:0] c16, c1;
  logic        f16, f1, v16, v1;

  int n_checks = 0;
  int n_fail   = 0;

  // Dark rectangle used by drive_line (inclusive bounds, bench coordinates).
  int rx0, rx1, ry0, ry1;

  typedef struct {
    int l;
    int r;
    int t;
    int b;
    int c;
  } exp_t;

  exp_t q[$];
  exp_t em;
  logic        fe;
  logic [9:0]  el, er;
  logic [8:0]  et, eb;

  bin_bbox_detect #(.MIN_PIXELS(16)) dut (
    .clk(clk), .reset(reset), .bin(bin), .in_href(in_href),
    .in_vsync(in_vsync), .in_clken(in_clken),
    .box_left(l16), .box_right(r16), .box_top(t16), .box_bottom(b16),
    .pix_count(c16), .box_found(f16), .box_valid(v16)
  );

  bin_bbox_detect #(.MIN_PIXELS(1)) dut1 (
    .clk(clk), .reset(reset), .bin(bin), .in_href(in_href),
    .in_vsync(in_vsync), .in_clken(in_clken),
    .box_left(l1), .box_right(r1), .box_top(t1), .box_bottom(b1),
    .pix_count(c1), .box_found(f1), .box_valid(v1)
  );

  always #5 clk = ~clk;

  // Scoreboard: every box_valid pops one expected frame and checks both DUTs.
  always @(negedge clk) begin
    if (v16 || v1) begin
      n_checks++;
      if (v16 !== v1) begin
        n_fail++;
        $display("FAIL valid_pair: dut16 valid=%0b dut1 valid=%0b", v16, v1);
      end
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: box_valid=1 at %0t, required no result", $time);
      end else begin
        em = q.pop_front();
        fe = (em.c >= 16);
        el = fe ? 10'(em.l) : 10'd0;
        er = fe ? 10'(em.r) : 10'd0;
        et = fe ? 9'(em.t)  : 9'd0;
        eb = fe ? 9'(em.b)  : 9'd0;
        n_checks++;
        if ({f16, l16, r16, t16, b16, c16} !== {fe, el, er, et, eb, 19'(em.c)}) begin
          n_fail++;
          $display("FAIL result_min16: got f=%0b l=%0d r=%0d t=%0d b=%0d c=%0d, want f=%0b l=%0d r=%0d t=%0d b=%0d c=%0d",
                   f16, l16, r16, t16, b16, c16, fe, el, er, et, eb, em.c);
        end
        fe = (em.c >= 1);
        el = fe ? 10'(em.l) : 10'd0;
        er = fe ? 10'(em.r) : 10'd0;
        et = fe ? 9'(em.t)  : 9'd0;
        eb = fe ? 9'(em.b)  : 9'd0;
        n_checks++;
        if ({f1, l1, r1, t1, b1, c1} !== {fe, el, er, et, eb, 19'(em.c)}) begin
          n_fail++;
          $display("FAIL result_min1: got f=%0b l=%0d r=%0d t=%0d b=%0d c=%0d, want f=%0b l=%0d r=%0d t=%0d b=%0d c=%0d",
                   f1, l1, r1, t1, b1, c1, fe, el, er, et, eb, em.c);
        end
      end
    end
  end

  function automatic bit is_dark(input int xx, input int yy);
    return (xx >= rx0) && (xx <= rx1) && (yy >= ry0) && (yy <= ry1);
  endfunction

  // One line of npix valid pixels; tog inserts an invalid cycle between each.
  task automatic drive_line(input int npix, input int row, input bit tog);
    int v = 0;
    int cyc = 0;
    while (v < npix) begin
      @(posedge clk); #1;
      in_href  = 1'b1;
      in_clken = tog ? ((cyc % 2) == 0) : 1'b1;
      if (in_clken) begin
        bin = is_dark(v, row) ? 1'b0 : 1'b1;
        v++;
      end else begin
        bin = 1'b0;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_href = 1'b0; in_clken = 1'b0; bin = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive_frame(input int nlines, input int npix);
    for (int r = 0; r < nlines; r++) drive_line(npix, r, 1'b0);
  endtask

  task automatic vsync_pulse();
    @(posedge clk); #1; in_vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1; in_vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({f16, l16, r16, t16, b16, c16, v16} !== '0) begin
      n_fail++;
      $display("FAIL reset_min16: got %h, want 0", {f16, l16, r16, t16, b16, c16, v16});
    end
    n_checks++;
    if ({f1, l1, r1, t1, b1, c1, v1} !== '0) begin
      n_fail++;
      $display("FAIL reset_min1: got %h, want 0", {f1, l1, r1, t1, b1, c1, v1});
    end
    reset = 1'b0;
    // Partial frame with ink, then the aligning vsync: no result allowed.
    rx0 = 0; rx1 = 5; ry0 = 0; ry1 = 1;
    drive_frame(2, 8);
    vsync_pulse();
    n_checks++;
    if ({f16, c16, f1, c1} !== '0) begin
      n_fail++;
      $display("FAIL sync_no_update: got f16=%0b c16=%0d f1=%0b c1=%0d, want all 0", f16, c16, f1, c1);
    end
  endtask

  task automatic test_single_pixel();
    rx0 = 100; rx1 = 100; ry0 = 50; ry1 = 50;
    drive_frame(51, 101);
    q.push_back('{100, 100, 50, 50, 1});
    vsync_pulse();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL single_arrived: pending=%0d, want 0", q.size());
    end
  endtask

  task automatic test_rectangle();
    rx0 = 200; rx1 = 259; ry0 = 120; ry1 = 219;
    drive_frame(220, 260);
    q.push_back('{200, 259, 120, 219, 6000});
    vsync_pulse();
    rx0 = -1; rx1 = -1; ry0 = -1; ry1 = -1;
    drive_frame(4, 30);
    q.push_back('{0, 0, 0, 0, 0});
    vsync_pulse();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rect_arrived: pending=%0d, want 0", q.size());
    end
  endtask

  task automatic test_min_pixels();
    rx0 = 10; rx1 = 19; ry0 = 1; ry1 = 1;
    drive_frame(3, 25);
    q.push_back('{10, 19, 1, 1, 10});
    vsync_pulse();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL minpix_arrived: pending=%0d, want 0", q.size());
    end
  endtask

  task automatic test_reset_midframe();
    rx0 = 0; rx1 = 19; ry0 = 0; ry1 = 4;
    drive_frame(5, 20);
    @(posedge clk); #1;
    in_href = 1'b1; in_clken = 1'b1; bin = 1'b0;
    #2; reset = 1'b1;
    #1;
    n_checks++;
    if ({f16, l16, r16, t16, b16, c16, f1, l1, r1, t1, b1, c1} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_clear: got c16=%0d f1=%0b l1=%0d c1=%0d, want all 0", c16, f1, l1, c1);
    end
    @(posedge clk); #1;
    reset = 1'b0; in_href = 1'b0; in_clken = 1'b0; bin = 1'b1;
    drive_frame(2, 10);
    vsync_pulse();
    rx0 = 3; rx1 = 3; ry0 = 2; ry1 = 2;
    drive_frame(3, 10);
    q.push_back('{3, 3, 2, 2, 1});
    @(posedge clk); #1; in_vsync = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({v16, v1} !== 2'b11) begin
      n_fail++;
      $display("FAIL valid_latency: got v16=%0b v1=%0b, want 1 1", v16, v1);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({v16, v1} !== 2'b00) begin
      n_fail++;
      $display("FAIL valid_width: got v16=%0b v1=%0b, want 0 0", v16, v1);
    end
    in_vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_arrived: pending=%0d, want 0", q.size());
    end
  endtask

  task automatic test_clken_toggle();
    rx0 = 299; rx1 = 299; ry0 = 0; ry1 = 0;
    drive_line(320, 0, 1'b1);
    q.push_back('{299, 299, 0, 0, 1});
    vsync_pulse();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL clken_arrived: pending=%0d, want 0", q.size());
    end
  endtask

  task automatic test_window();
    rx0 = 650; rx1 = 650; ry0 = 0; ry1 = 0;
    drive_line(700, 0, 1'b0);
    rx0 = 0; rx1 = 0; ry0 = 480; ry1 = 499;
    for (int r = 1; r < 500; r++) drive_line(1, r, 1'b0);
    q.push_back('{0, 0, 0, 0, 0});
    vsync_pulse();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL window_arrived: pending=%0d, want 0", q.size());
    end
  endtask

  // Ink on the very last pixel before the frame-end edge must be counted.
  task automatic test_last_pixel();
    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1;
      in_href = 1'b1; in_clken = 1'b1;
      bin = (v == 0 || v == 4) ? 1'b0 : 1'b1;
    end
    q.push_back('{0, 4, 0, 0, 2});
    @(posedge clk); #1;
    in_vsync = 1'b1; bin = 1'b0;
    @(posedge clk); #1;
    in_href = 1'b0; in_clken = 1'b0; bin = 1'b1;
    repeat (3) @(posedge clk);
    #1; in_vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL last_pixel_arrived: pending=%0d, want 0", q.size());
    end
  endtask

  initial begin
    reset = 1'b1; bin = 1'b1; in_href = 1'b0; in_vsync = 1'b0; in_clken = 1'b0;
    rx0 = -1; rx1 = -1; ry0 = -1; ry1 = -1;
    test_reset();
    test_single_pixel();
    test_rectangle();
    test_min_pixels();
    test_reset_midframe();
    test_clken_toggle();
    test_window();
    test_last_pixel();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin_bbox_detect.md
# bin_bbox_detect

Per-frame bounding-box locator for the binarized camera stream. It sits directly downstream of the binarization stage and consumes its `bin`/`href`/`vsync`/`clken` outputs. It tracks pixel coordinates and accumulates the min/max column and row of all foreground pixels plus their count. At each frame boundary it publishes the box of the written figure for the crop/recognition stage.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `XW`, 10: column coordinate width; must satisfy 2^XW ≥ H_ACTIVE.
- `YW`, 9: row coordinate width; must satisfy 2^YW ≥ V_ACTIVE.
- `CW`, 19: pixel-count width.
- `FG_LEVEL`, 1'b0: `bin` value treated as foreground (dark ink on white paper).
- `MIN_PIXELS`, 16: minimum foreground count for a box to be declared found.

Ports:
- `clk`, in, 1: pixel clock.
- `reset`, in, 1: asynchronous, active-high.
- `bin`, in, 1: binarized pixel.
- `in_href`, in, 1: line active.
- `in_vsync`, in, 1: high during vertical blanking; its rising edge ends a frame.
- `in_clken`, in, 1: pixel-valid qualifier.
- `box_left`, out, XW: min foreground column.
- `box_right`, out, XW: max foreground column.
- `box_top`, out, YW: min foreground row.
- `box_bottom`, out, YW: max foreground row.
- `pix_count`, out, CW: foreground pixel count of the last frame.
- `box_found`, out, 1: last frame had count ≥ MIN_PIXELS.
- `box_valid`, out, 1: one-cycle pulse when the outputs above are updated.

## Operation
- Pixel event: `in_href & in_clken & ~in_vsync`. All other cycles never touch the accumulators.
- Column counter `x`:
  - Cleared when `in_href` = 0.
  - Increments after each pixel event and saturates at H_ACTIVE.
  - A pixel event sees coordinate x = value before the increment.
- Row counter `y`:
  - Increments on the `in_href` falling edge, detected with a registered copy `href_d`; saturates at V_ACTIVE.
  - Cleared on the `in_vsync` rising edge.
- Foreground pixel: a pixel event with `bin == FG_LEVEL`, x < H_ACTIVE and y < V_ACTIVE. Foreground pixels outside the active window are ignored.
- On each foreground pixel:
  - `min_x`/`max_x`/`min_y`/`max_y` update with unsigned compares.
  - `cnt` increments and saturates at 2^CW−1.
- Accumulators clear at frame start:
  - `min_x` ← H_ACTIVE−1, `max_x` ← 0.
  - `min_y` ← V_ACTIVE−1, `max_y` ← 0.
  - `cnt` ← 0.
- FSM, two states:
  - SYNC (reset state): accumulators ignored. On the first `in_vsync` rising edge, clear accumulators and go to ACCUM. No `box_valid` on this transition, since the partial frame is discarded.
  - ACCUM: accumulate. On each `in_vsync` rising edge:
    - Latch results into the outputs and pulse `box_valid`.
    - Clear accumulators on the same edge.
    - Stay in ACCUM.
- Result latch:
  - If `cnt ≥ MIN_PIXELS`: `box_found` = 1, and the coordinates and count are copied.
  - Else: `box_found` = 0 and all coordinates = 0; `pix_count` still gets `cnt`.

## Timing
- Reset values: all outputs 0, FSM = SYNC, `x`/`y`/`href_d`/`vsync_d` = 0, accumulators at their cleared values.
- Frame end is the clock edge where `in_vsync` = 1 and `vsync_d` = 0. On that edge, outputs are registered and `box_valid` is set. `box_valid` is high for exactly the following cycle.
- Outputs hold until the next frame end; they never change mid-frame.
- A foreground pixel event on the cycle just before the frame-end edge is included in that frame's result.
- Reset asserted mid-frame: immediate clear, return to SYNC. The next frame result appears only after two `in_vsync` rising edges.
- Throughput: one pixel per clock; `in_clken` may toggle arbitrarily within `in_href`.
- Latency to the result is 1 clock after the `in_vsync` rise.

## Test plan
- Run with a single dark pixel at (x=100, y=50) and MIN_PIXELS=1. After two vsync rises: `box_valid` pulses once with left=right=100, top=bottom=50, count=1, found=1.
- Draw a dark rectangle at columns 200–259, rows 120–219, with the second frame all white. The first result is 200/259/120/219, count=6000, found=1. The second is found=0, all coordinates 0, count=0.
- With 10 dark pixels and MIN_PIXELS=16: found=0, count=10, coordinates 0.
- Toggle `clken` every other cycle within `href` and place a dark pixel on the 300th valid pixel. Require left=299, with the count unaffected by invalid cycles.
- Feed 700 valid pixels per line, dark only at pixel index 650, and 500 lines with the last lines dark. The out-of-window pixels are ignored, so count=0 and found=0.
- Assert reset mid-frame, then drive frames. There is no `box_valid` on the first vsync rise after reset; the result arrives exactly one cycle after the second rise and matches the stimulus of the complete frame only.
